escalonador_carga: RTL and testbench

//   Round-robin scheduler sharing one power relay among NUM_REQ controladora zones.

---
 rtl/escalonador_carga.sv | 157 +++++++++++++++
 tb/tb_escalonador_carga.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/escalonador_carga.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : escalonador_carga
// Description : Round-robin scheduler sharing one power relay among NUM_REQ
//               zones, with a per-grant hold cap and a dead-time between grants.
// Revision    : 1.0 - initial release
// ============================================================================
module escalonador_carga #(
    parameter int  NUM_REQ    = 4,
    parameter int  MAX_HOLD_T = 30000,
    parameter int  GUARD_T    = 300,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    grant_id,
    output logic               busy,
    output logic               timeout
);

    localparam int c_HOLD_W  = $clog2(MAX_HOLD_T + 1);
    localparam int c_GUARD_W = $clog2(GUARD_T + 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_LAST  = c_HOLD_W'(MAX_HOLD_T - 1);
    localparam logic [c_GUARD_W-1:0] c_GUARD_LAST = c_GUARD_W'(GUARD_T - 1);
    localparam logic [ID_W-1:0]      c_LAST_ID    = ID_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    state_t               r_state, w_state_nxt;
    logic [NUM_REQ-1:0]   r_gnt, w_gnt_nxt;
    logic [ID_W-1:0]      r_grant_id, w_id_nxt;
    logic                 r_busy;
    logic                 r_timeout, w_timeout_nxt;
    logic [ID_W-1:0]      r_ptr, w_ptr_nxt;
    logic [NUM_REQ-1:0]   r_lock, w_lock_set;
    logic [c_HOLD_W-1:0]  r_hold, w_hold_nxt;
    logic [c_GUARD_W-1:0] r_guard, w_guard_nxt;

    logic [NUM_REQ-1:0]   w_elig;
    logic [2*NUM_REQ-1:0] w_elig_dbl;
    logic [NUM_REQ-1:0]   w_elig_rot;
    logic                 w_found;
    logic [ID_W-1:0]      w_winner;
    logic [ID_W:0]        w_sum;
    logic                 w_release;
    logic [ID_W-1:0]      w_ptr_after;

    assign w_elig = req & ~r_lock;

    // Rotate eligibility so bit 0 is the zone at ptr; first set bit wins.
    always_comb begin
        w_elig_dbl = {w_elig, w_elig} >> r_ptr;
        w_elig_rot = w_elig_dbl[NUM_REQ-1:0];
        w_found    = 1'b0;
        w_winner   = '0;
        w_sum      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && w_elig_rot[k]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (ID_W+1)'(k);
                if (w_sum >= (ID_W+1)'(NUM_REQ)) begin
                    w_sum = w_sum - (ID_W+1)'(NUM_REQ);
                end
                w_winner = w_sum[ID_W-1:0];
            end
        end
    end

    // r_gnt is one-hot on the owner while granted, so masking selects its bits.
    assign w_release   = ~(|(req & r_gnt)) | (|(done & r_gnt));
    assign w_ptr_after = (r_grant_id == c_LAST_ID) ? '0 : r_grant_id + ID_W'(1);

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_id_nxt      = r_grant_id;
        w_ptr_nxt     = r_ptr;
        w_hold_nxt    = r_hold;
        w_guard_nxt   = r_guard;
        w_timeout_nxt = 1'b0;
        w_lock_set    = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_gnt_nxt   = NUM_REQ'(1) << w_winner;
                    w_id_nxt    = w_winner;
                    w_hold_nxt  = '0;
                end
            end
            ST_GRANT: begin
                if (w_release || (r_hold == c_HOLD_LAST)) begin
                    w_state_nxt = ST_GUARD;
                    w_gnt_nxt   = '0;
                    w_guard_nxt = '0;
                    w_ptr_nxt   = w_ptr_after;
                    if (!w_release) begin
                        w_timeout_nxt = 1'b1;
                        w_lock_set    = NUM_REQ'(1) << r_grant_id;
                    end
                end else begin
                    w_hold_nxt = r_hold + c_HOLD_W'(1);
                end
            end
            ST_GUARD: begin
                if (r_guard == c_GUARD_LAST) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_guard_nxt = r_guard + c_GUARD_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_grant_id <= '0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_ptr      <= '0;
            r_lock     <= '0;
            r_hold     <= '0;
            r_guard    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_gnt      <= w_gnt_nxt;
            r_grant_id <= w_id_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_timeout  <= w_timeout_nxt;
            r_ptr      <= w_ptr_nxt;
            r_lock     <= (r_lock | w_lock_set) & req;
            r_hold     <= w_hold_nxt;
            r_guard    <= w_guard_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign grant_id = r_grant_id;
    assign busy     = r_busy;
    assign timeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_escalonador_carga.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_escalonador_carga
// Description : Directed and randomized bench for escalonador_carga, checked
//               against a timestamp-style behavioural scheduler model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_escalonador_carga;

    localparam int N          = 4;
    localparam int MAX_HOLD_T = 200;
    localparam int GUARD_T    = 12;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [1:0]   grant_id;
    logic         busy;
    logic         timeout;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: who owns the relay, for how long, and guard time left.
    int           m_owner;
    int           m_last;
    int           m_held;
    int           m_guard_left;
    int           m_ptr;
    logic [N-1:0] m_lock;
    logic         m_timeout;

    int gap, cnt, rst_left, tog_div, done_div;
    int order [4];

    escalonador_carga #(
        .NUM_REQ   (N),
        .MAX_HOLD_T(MAX_HOLD_T),
        .GUARD_T   (GUARD_T)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .grant_id(grant_id),
        .busy    (busy),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s at %0t: observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner      = -1;
        m_last       = 0;
        m_held       = 0;
        m_guard_left = 0;
        m_ptr        = 0;
        m_lock       = '0;
        m_timeout    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] rq, input logic [N-1:0] dn);
        logic [N-1:0] old_lock;
        old_lock  = m_lock;
        m_timeout = 1'b0;
        if (m_owner >= 0) begin
            m_held++;
            if (!rq[m_owner] || dn[m_owner] || m_held == MAX_HOLD_T) begin
                if (rq[m_owner] && !dn[m_owner]) begin
                    m_timeout        = 1'b1;
                    m_lock[m_owner]  = 1'b1;
                end
                m_ptr        = (m_owner + 1) % N;
                m_owner      = -1;
                m_guard_left = GUARD_T;
            end
        end else if (m_guard_left > 0) begin
            m_guard_left--;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (rq[(m_ptr + k) % N] && !old_lock[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_held  = 0;
                    break;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!rq[i]) m_lock[i] = 1'b0;
        end
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        check("gnt", gnt, eg);
        check("grant_id", grant_id, m_last);
        check("busy", busy, (m_owner >= 0) || (m_guard_left > 0));
        check("timeout", timeout, m_timeout);
        check("onehot0", $onehot0(gnt), 1);
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step(req, done);
        #1;
        check_all();
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b0;
        repeat (cycles) tick();
        rst = 1'b1;
    endtask

    // Ticks until a grant appears; gap counts guard-state samples seen on the way.
    task automatic wait_gnt(input int limit, output int gap_o);
        int waited;
        waited = 0;
        gap_o  = 0;
        while (gnt == '0 && waited < limit) begin
            if (busy) gap_o++;
            tick();
            waited++;
        end
        n_checks++;
        assert (gnt != '0) else begin
            n_errors++;
            $error("FAIL wait_gnt: no grant within %0d cycles, observed gnt=%b", limit, gnt);
        end
    endtask

    initial begin
        rst  = 1'b0;
        req  = '0;
        done = '0;
        model_reset();

        // Reset state and single-zone grant latency.
        do_reset(3);
        check("rst_gnt", gnt, 0);
        check("rst_busy", busy, 0);
        req = 4'b0010;
        tick();
        check("t1_gnt", gnt, 4'b0010);
        check("t1_id", grant_id, 1);
        check("t1_busy", busy, 1);

        // Owner drops: guard length, then pointer has moved past zone 1.
        repeat (3) tick();
        req = '0;
        tick();
        check("t2_gnt_off", gnt, 0);
        cnt = 0;
        while (busy && cnt < 1000) begin
            cnt++;
            tick();
        end
        check("t2_guard_len", cnt, GUARD_T);
        req = 4'b1111;
        tick();
        check("t2_ptr_id", grant_id, 2);
        check("t2_ptr_gnt", gnt, 4'b0100);

        // Round-robin wrap with done pulses.
        req = '0;
        do_reset(3);
        req = 4'b1011;
        for (int g = 0; g < 4; g++) begin
            wait_gnt(GUARD_T + 20, gap);
            order[g] = grant_id;
            if (g > 0) check("t3_gap", gap, GUARD_T);
            repeat (49) tick();
            done = gnt;
            tick();
            done = '0;
        end
        check("t3_order0", order[0], 0);
        check("t3_order1", order[1], 1);
        check("t3_order2", order[2], 3);
        check("t3_order3", order[3], 0);

        // Hold cap, timeout pulse and lockout until req toggles.
        req = '0;
        do_reset(3);
        req = 4'b0100;
        wait_gnt(20, gap);
        check("t4_id", grant_id, 2);
        cnt = 0;
        while (gnt[2] && cnt < MAX_HOLD_T + 50) begin
            cnt++;
            tick();
        end
        check("t4_hold_len", cnt, MAX_HOLD_T);
        check("t4_timeout", timeout, 1);
        tick();
        check("t4_timeout_pulse", timeout, 0);
        repeat (3 * GUARD_T) tick();
        check("t4_locked", gnt, 0);
        req = '0;
        tick();
        req = 4'b0100;
        wait_gnt(GUARD_T + 20, gap);
        check("t4_regrant", gnt, 4'b0100);

        // Release on the cap cycle: no timeout, no lockout.
        repeat (MAX_HOLD_T - 1) tick();
        done = 4'b0100;
        tick();
        done = '0;
        check("t5_gnt_off", gnt, 0);
        check("t5_no_timeout", timeout, 0);
        check("t5_busy", busy, 1);
        wait_gnt(GUARD_T + 20, gap);
        check("t5_no_lock", grant_id, 2);

        // Asynchronous reset mid-grant.
        #2 rst = 1'b0;
        #1;
        model_reset();
        check("t6_async_gnt", gnt, 0);
        check("t6_async_busy", busy, 0);
        check("t6_async_id", grant_id, 0);
        req = 4'b1100;
        repeat (400) tick();
        rst = 1'b1;
        wait_gnt(20, gap);
        check("t6_lowest", grant_id, 2);

        // Random concurrent req/done/rst mix.
        rst_left = 0;
        for (int c = 0; c < 3000; c++) begin
            tog_div  = (c < 1500) ? 8 : 300;
            done_div = (c < 1500) ? 6 : 200;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(tog_div - 1) == 0) req[i] = ~req[i];
                done[i] = ($urandom_range(done_div - 1) == 0);
            end
            if (rst && $urandom_range(499) == 0) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                check_all();
                rst_left = $urandom_range(20, 1);
            end else if (!rst) begin
                rst_left--;
                if (rst_left <= 0) rst = 1'b1;
            end
            tick();
        end
        rst = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
